// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared CPU pipeline constants for retire-slot and bypass records.
package wb_stage_pkg;
  localparam int SLOT_BUS_W = 71;
  localparam int FWD_BUS_W = 38;
  localparam int SLOT_V = 70;
  localparam int SLOT_WE = 69;
  localparam int SLOT_DEST_LO = 64;
  localparam int SLOT_PC_LO = 32;
  localparam int SLOT_RES_LO = 0;
  typedef enum logic {P0 = 1'b0, P1 = 1'b1} phase_t;
endpackage

// File: rtl/wb_slot_decode.sv
// wb_slot_decode: unpacks one retire-slot record and computes its register-file write enable.
module wb_slot_decode
  import wb_stage_pkg::*;
(
  input  logic                  ws_valid,
  input  logic [SLOT_BUS_W-1:0] slot,
  output logic                  valid,
  output logic [4:0]            dest,
  output logic [31:0]           pc,
  output logic [31:0]           result,
  output logic                  wen
);
  assign valid = slot[SLOT_V];
  assign dest = slot[SLOT_DEST_LO +: 5];
  assign pc = slot[SLOT_PC_LO +: 32];
  assign result = slot[SLOT_RES_LO +: 32];
  assign wen = ws_valid & valid & slot[SLOT_WE] & (dest != 5'd0);
endmodule

// File: rtl/wb_stage.sv
// wb_stage: dual-slot writeback stage; DEBUG_TRACE_EN serialises retirement into two phases
// so the single-port retire trace can report each slot.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int SLOT_BUS_W = wb_stage_pkg::SLOT_BUS_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ms_to_ws_valid,
  output logic                      ws_allowin,
  input  logic [2*SLOT_BUS_W-1:0]   ms_to_ws_bus,
  output logic                      we_01,
  output logic [4:0]                waddr_01,
  output logic [31:0]               wdata_01,
  output logic                      we_02,
  output logic [4:0]                waddr_02,
  output logic [31:0]               wdata_02,
  output logic [2*FWD_BUS_W-1:0]    ws_fwd_bus,
  output logic [31:0]               debug_wb_pc,
  output logic [3:0]                debug_wb_rf_wen,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [31:0]               debug_wb_rf_wdata
);
  logic ws_valid;
  logic ws_ready_go;
  logic [2*SLOT_BUS_W-1:0] ws_bus;
  logic [1:0] sv;
  logic [1:0] wen;
  logic [4:0] dest [2];
  logic [31:0] pc [2];
  logic [31:0] result [2];
  logic [1:0] act;
  logic done0;
  logic collide;
  for (genvar i = 0; i < 2; i++) begin : g_slot
    wb_slot_decode u_dec (
      .ws_valid(ws_valid),
      .slot(ws_bus[i*SLOT_BUS_W +: SLOT_BUS_W]),
      .valid(sv[i]),
      .dest(dest[i]),
      .pc(pc[i]),
      .result(result[i]),
      .wen(wen[i])
    );
  end
  assign ws_allowin = !ws_valid | ws_ready_go;
  always_ff @(posedge clk) begin
    if (reset) ws_valid <= 1'b0;
    else if (ws_allowin) ws_valid <= ms_to_ws_valid;
    if (ms_to_ws_valid & ws_allowin) ws_bus <= ms_to_ws_bus;
  end
  // same-cycle writes to one register: the younger slot wins
  assign collide = act[0] & act[1] & wen[0] & wen[1] & (dest[0] == dest[1]);
  assign we_01 = act[0] & wen[0] & !collide;
  assign waddr_01 = dest[0];
  assign wdata_01 = result[0];
  assign we_02 = act[1] & wen[1];
  assign waddr_02 = dest[1];
  assign wdata_02 = result[1];
  assign ws_fwd_bus = {wen[1], dest[1], result[1], wen[0] & !done0, dest[0], result[0]};
`ifdef DEBUG_TRACE_EN
  phase_t phase, phase_nx;
  logic dual;
  logic ts;
  assign dual = sv[0] & sv[1];
  always_ff @(posedge clk) phase <= reset ? P0 : phase_nx;
  always_comb begin
    phase_nx = phase;
    ws_ready_go = 1'b1;
    act = 2'b01;
    done0 = 1'b0;
    if (phase == P1) begin
      act = 2'b10;
      done0 = 1'b1;
      phase_nx = P0;
    end else begin
      act = (sv == 2'b10) ? 2'b10 : 2'b01;
      ws_ready_go = !dual;
      phase_nx = (ws_valid & dual) ? P1 : P0;
    end
  end
  assign ts = act[1];
  assign debug_wb_pc = ws_valid ? pc[ts] : '0;
  assign debug_wb_rf_wen = {4{wen[ts]}};
  assign debug_wb_rf_wnum = ws_valid ? dest[ts] : '0;
  assign debug_wb_rf_wdata = ws_valid ? result[ts] : '0;
`else
  logic unused_fields;
  assign unused_fields = ^{pc[0], pc[1], sv};
  assign ws_ready_go = 1'b1;
  assign act = 2'b11;
  assign done0 = 1'b0;
  assign debug_wb_pc = '0;
  assign debug_wb_rf_wen = '0;
  assign debug_wb_rf_wnum = '0;
  assign debug_wb_rf_wdata = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage; expectations are tagged with the cycle they must appear in.
module tb_wb_stage;
`ifdef DEBUG_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  logic clk, reset, ms_to_ws_valid, ws_allowin;
  logic [141:0] ms_to_ws_bus;
  logic we_01, we_02;
  logic [4:0] waddr_01, waddr_02, debug_wb_rf_wnum;
  logic [31:0] wdata_01, wdata_02, debug_wb_pc, debug_wb_rf_wdata;
  logic [75:0] ws_fwd_bus;
  logic [3:0] debug_wb_rf_wen;
  typedef struct {
    int tag;
    bit idle, w1, w2, f0, f1, allow;
    int dsel;
    bit [4:0] d0, d1;
    bit [31:0] r0, r1, p0, p1;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int scyc = 0, mcyc = 0, checks = 0, errors = 0;
  logic [141:0] b;
  wb_stage dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_to_ws_bus(ms_to_ws_bus), .we_01(we_01), .waddr_01(waddr_01), .wdata_01(wdata_01),
    .we_02(we_02), .waddr_02(waddr_02), .wdata_02(wdata_02), .ws_fwd_bus(ws_fwd_bus),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [141:0] ent(logic v0, logic g0, logic [4:0] d0, logic [31:0] p0, logic [31:0] r0,
                                       logic v1, logic g1, logic [4:0] d1, logic [31:0] p1, logic [31:0] r1);
    return {v1, g1, d1, p1, r1, v0, g0, d0, p0, r0};
  endfunction
  function automatic exp_t ex(int tag, logic [141:0] bus, bit w1, bit w2, bit f0, bit f1, int dsel, bit allow);
    exp_t x;
    x.tag = tag; x.idle = 1'b0; x.w1 = w1; x.w2 = w2; x.f0 = f0; x.f1 = f1;
    x.dsel = dsel; x.allow = allow;
    x.d0 = bus[68:64]; x.p0 = bus[63:32]; x.r0 = bus[31:0];
    x.d1 = bus[139:135]; x.p1 = bus[134:103]; x.r1 = bus[102:71];
    return x;
  endfunction
  function automatic exp_t idle(int tag);
    exp_t x = ex(tag, '0, 0, 0, 0, 0, 0, 1);
    x.idle = 1'b1;
    return x;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, req, mcyc);
    end
  endtask
  always @(negedge clk) begin
    mcyc++;
    while (sb.size() != 0 && sb[0].tag <= mcyc) begin
      e = sb.pop_front();
      chk("we_01", we_01, e.w1);
      if (e.w1) begin chk("waddr_01", waddr_01, e.d0); chk("wdata_01", wdata_01, e.r0); end
      chk("we_02", we_02, e.w2);
      if (e.w2) begin chk("waddr_02", waddr_02, e.d1); chk("wdata_02", wdata_02, e.r1); end
      chk("fwd_v0", ws_fwd_bus[37], e.f0);
      if (e.f0) begin chk("fwd_d0", ws_fwd_bus[36:32], e.d0); chk("fwd_r0", ws_fwd_bus[31:0], e.r0); end
      chk("fwd_v1", ws_fwd_bus[75], e.f1);
      if (e.f1) begin chk("fwd_d1", ws_fwd_bus[74:70], e.d1); chk("fwd_r1", ws_fwd_bus[69:38], e.r1); end
      chk("allowin", ws_allowin, e.allow);
`ifdef DEBUG_TRACE_EN
      chk("dbg_wen", debug_wb_rf_wen, e.dsel == 0 ? 32'h0 : 32'hF);
      if (e.dsel != 0 || e.idle) begin
        chk("dbg_pc", debug_wb_pc, e.dsel == 2 ? e.p1 : e.p0);
        chk("dbg_wnum", debug_wb_rf_wnum, e.dsel == 2 ? e.d1 : e.d0);
        chk("dbg_wdata", debug_wb_rf_wdata, e.dsel == 2 ? e.r1 : e.r0);
      end
`else
      chk("dbg_wen", debug_wb_rf_wen, 0);
      chk("dbg_pc", debug_wb_pc, 0);
      chk("dbg_wnum", debug_wb_rf_wnum, 0);
      chk("dbg_wdata", debug_wb_rf_wdata, 0);
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    scyc++;
  endtask
  task automatic drive(logic v, logic [141:0] bus);
    ms_to_ws_valid = v;
    ms_to_ws_bus = bus;
  endtask
  task automatic quiet();
    drive(1'b0, '0);
    sb.push_back(idle(scyc + 1));
    step();
  endtask
  task automatic single(logic [141:0] bus, bit w1, bit w2, bit f0, bit f1, int dsel);
    drive(1'b1, bus);
    sb.push_back(ex(scyc + 1, bus, w1, w2, f0, f1, dsel, 1));
    step();
  endtask
  task automatic dual(logic [141:0] bus, bit coll);
    drive(1'b1, bus);
    if (TR) begin
      sb.push_back(ex(scyc + 1, bus, 1, 0, 1, 1, 1, 0));
      sb.push_back(ex(scyc + 2, bus, 0, 1, 0, 1, 2, 1));
      step();
      step();
    end else begin
      sb.push_back(ex(scyc + 1, bus, !coll, 1, 1, 1, 0, 1));
      step();
    end
  endtask
  initial begin
    reset = 1'b1;
    drive(1'b0, '0);
    sb.push_back(idle(1));
    sb.push_back(idle(2));
    step();
    step();
    reset = 1'b0;
    single(ent(1, 1, 5, 32'hBFC00000, 32'h1234, 0, 0, 0, 0, 0), 1, 0, 1, 0, 1);
    quiet();
    dual(ent(1, 1, 3, 32'h100, 32'hA, 1, 1, 3, 32'h104, 32'hB), 1);
    quiet();
    dual(ent(1, 1, 4, 32'h200, 32'h44, 1, 1, 6, 32'h204, 32'h66), 0);
    quiet();
    single(ent(1, 1, 0, 32'h300, 32'h55, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
    single(ent(0, 1, 9, 32'h310, 32'h99, 0, 1, 10, 32'h314, 32'hAA), 0, 0, 0, 0, 0);
    single(ent(0, 0, 0, 0, 0, 1, 1, 12, 32'h320, 32'hC0DE), 0, 1, 0, 1, 2);
    quiet();
    single(ent(1, 1, 1, 32'h400, 32'h11, 0, 0, 0, 0, 0), 1, 0, 1, 0, 1);
    single(ent(1, 1, 2, 32'h404, 32'h22, 0, 0, 0, 0, 0), 1, 0, 1, 0, 1);
    single(ent(0, 0, 0, 0, 0, 1, 1, 13, 32'h408, 32'h33), 0, 1, 0, 1, 2);
    single(ent(1, 1, 14, 32'h40C, 32'h44, 0, 0, 0, 0, 0), 1, 0, 1, 0, 1);
    quiet();
    dual(ent(1, 1, 15, 32'h500, 32'hF5, 1, 1, 16, 32'h504, 32'hF6), 0);
    dual(ent(1, 1, 17, 32'h508, 32'hF7, 1, 1, 18, 32'h50C, 32'hF8), 0);
    quiet();
    b = ent(1, 1, 7, 32'h600, 32'h77, 1, 1, 8, 32'h604, 32'h88);
    drive(1'b1, b);
    if (TR) begin
      sb.push_back(ex(scyc + 1, b, 1, 0, 1, 1, 1, 0));
      sb.push_back(ex(scyc + 2, b, 0, 1, 0, 1, 2, 1));
      step();
      drive(1'b0, '0);
      step();
    end else begin
      sb.push_back(ex(scyc + 1, b, 1, 1, 1, 1, 0, 1));
      step();
      drive(1'b0, '0);
    end
    reset = 1'b1;
    sb.push_back(idle(scyc + 1));
    step();
    reset = 1'b0;
    sb.push_back(idle(scyc + 1));
    step();
    dual(ent(1, 1, 19, 32'h700, 32'h19, 1, 1, 20, 32'h704, 32'h20), 0);
    quiet();
    step();
    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
